// File: rtl/systolic_array_if.sv
// Operand, write-port and readout bundle for systolic_array.
// master drives operands, row writes and row select; slave returns the
// selected accumulator row and the end-of-pass pulse.
interface systolic_array_if #(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter int DIM     = 8
);
  logic                              en;
  logic                              WrEn;
  logic signed [DIM-1:0][BITS_AB-1:0] A;
  logic signed [DIM-1:0][BITS_AB-1:0] B;
  logic signed [DIM-1:0][BITS_C-1:0]  Cin;
  logic        [$clog2(DIM)-1:0]      Crow;
  logic signed [DIM-1:0][BITS_C-1:0]  Cout;
  logic                              done;

  modport master (output en, WrEn, A, B, Cin, Crow, input Cout, done);
  modport slave  (input en, WrEn, A, B, Cin, Crow, output Cout, done);
endinterface

// File: rtl/systolic_array.sv
// DIM x DIM output-stationary systolic multiply-accumulate array.
// A streams left-to-right along rows, B top-to-bottom along columns; each
// PE accumulates the product of the operands passing through it.
// A pass counter pulses done after 3*DIM-2 enabled cycles.
// Build option: define SYSTOLIC_SAT_EN to make each accumulate saturate
// instead of wrapping modulo 2^BITS_C.

module systolic_pe #(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      wr,
  input  logic        [BITS_C-1:0]  wdata,
  input  logic signed [BITS_AB-1:0] a_in,
  input  logic signed [BITS_AB-1:0] b_in,
  output logic signed [BITS_AB-1:0] a_q,
  output logic signed [BITS_AB-1:0] b_q,
  output logic signed [BITS_C-1:0]  c_q
);
  logic signed [2*BITS_AB-1:0] prod;
  logic signed [BITS_C-1:0]    prod_ext;
  logic signed [BITS_C-1:0]    c_next;

  assign prod     = a_in * b_in;
  assign prod_ext = BITS_C'(prod);

`ifdef SYSTOLIC_SAT_EN
  logic signed [BITS_C:0] sum;
  assign sum = (BITS_C+1)'(c_q) + (BITS_C+1)'(prod_ext);

  // Clamp on signed overflow: the two top bits of the widened sum disagree.
  always_comb begin
    c_next = sum[BITS_C-1:0];
    if (sum[BITS_C] != sum[BITS_C-1])
      c_next = sum[BITS_C] ? {1'b1, {(BITS_C-1){1'b0}}} : {1'b0, {(BITS_C-1){1'b1}}};
  end
`else
  assign c_next = c_q + prod_ext;
`endif

  // Operand pipeline and accumulator; a row write overrides the accumulate.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
    end else begin
      if (en) begin
        a_q <= a_in;
        b_q <= b_in;
      end
      if (wr)      c_q <= wdata;
      else if (en) c_q <= c_next;
    end
  end
endmodule

module systolic_array #(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter int DIM     = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  systolic_array_if.slave bus
);
  localparam int RW   = $clog2(DIM);
  localparam int PASS = 3*DIM - 2;
  localparam int CW   = $clog2(PASS + 1);

  logic [DIM-1:0][DIM-1:0][BITS_AB-1:0] a_q;
  logic [DIM-1:0][DIM-1:0][BITS_AB-1:0] b_q;
  logic [DIM-1:0][DIM-1:0][BITS_C-1:0]  c_q;
  logic [DIM-1:0][BITS_C-1:0]           cout;
  logic [CW-1:0]                        pass_cnt;
  logic                                 done_q;
  logic                                 unused_edge;

  for (genvar i = 0; i < DIM; i++) begin : g_row
    localparam logic [RW-1:0] ROW = RW'(i);
    for (genvar j = 0; j < DIM; j++) begin : g_col
      logic [BITS_AB-1:0] a_in, b_in;
      if (j == 0) begin : g_a_edge
        assign a_in = bus.A[i];
      end else begin : g_a_int
        assign a_in = a_q[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign b_in = bus.B[j];
      end else begin : g_b_int
        assign b_in = b_q[i-1][j];
      end

      systolic_pe #(.BITS_AB(BITS_AB), .BITS_C(BITS_C)) u_pe (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (bus.en),
        .wr    (bus.WrEn && (bus.Crow == ROW)),
        .wdata (bus.Cin[j]),
        .a_in  (a_in),
        .b_in  (b_in),
        .a_q   (a_q[i][j]),
        .b_q   (b_q[i][j]),
        .c_q   (c_q[i][j])
      );
    end
  end

  // Operands leaving the far edge of the array go nowhere.
  assign unused_edge = ^{a_q, b_q};

  // Row readout; a select beyond DIM-1 reads zero.
  always_comb begin
    cout = '0;
    for (int r = 0; r < DIM; r++)
      if (bus.Crow == RW'(r)) cout = c_q[r];
  end
  assign bus.Cout = cout;

  // Pass counter: wraps after PASS enabled cycles and raises done for one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pass_cnt <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.en) begin
        if (pass_cnt == CW'(PASS - 1)) begin
          pass_cnt <= '0;
          done_q   <= 1'b1;
        end else begin
          pass_cnt <= pass_cnt + 1'b1;
        end
      end
    end
  end
  assign bus.done = done_q;
endmodule

// File: tb/tb_systolic_array.sv
// Self-checking bench for systolic_array: randomized matrices checked
// against a plain matrix-product reference model.
module tb_systolic_array;
  localparam int BITS_AB = 8;
  localparam int BITS_C  = 16;
  localparam int DIM     = 8;
  localparam int PASS    = 3*DIM - 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  systolic_array_if #(.BITS_AB(BITS_AB), .BITS_C(BITS_C), .DIM(DIM)) bus ();
  systolic_array #(.BITS_AB(BITS_AB), .BITS_C(BITS_C), .DIM(DIM)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  int Am [DIM][DIM];
  int Bm [DIM][DIM];
  int Cx [DIM][DIM];
  int done_first, done_cnt;
  logic [DIM-1:0][BITS_C-1:0] wr_row;
  logic [DIM-1:0][BITS_C-1:0] got [DIM];
  logic [DIM-1:0][BITS_C-1:0] er;

  function automatic int rnd8();
    return int'($urandom_range(255)) - 128;
  endfunction

  function automatic int accum(int acc, int p);
    int s;
    s = acc + p;
`ifdef SYSTOLIC_SAT_EN
    if (s > 32767)  return 32767;
    if (s < -32768) return -32768;
    return s;
`else
    return int'(shortint'(s));
`endif
  endfunction

  // C = A*B summed in k order; wr_at >= 0 models a row-3 write of 0x0100
  // on that enabled cycle, with term k of PE(i,j) landing on cycle k+i+j.
  function automatic void model(int wr_at);
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        int acc, m;
        bit written;
        acc = 0; written = 0;
        for (int k = 0; k < DIM; k++) begin
          m = k + i + j;
          if (i == 3 && wr_at >= 0 && !written && m >= wr_at) begin
            acc = 256; written = 1;
            if (m == wr_at) continue;
          end
          acc = accum(acc, Am[i][k] * Bm[k][j]);
        end
        if (i == 3 && wr_at >= 0 && !written) acc = 256;
        Cx[i][j] = acc;
      end
  endfunction

  task automatic idle();
    bus.en = 1'b0; bus.WrEn = 1'b0; bus.A = '0; bus.B = '0;
    bus.Cin = '0; bus.Crow = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic rand_mats();
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        Am[i][j] = rnd8(); Bm[i][j] = rnd8();
      end
  endtask

  task automatic read_C();
    for (int r = 0; r < DIM; r++) begin
      bus.Crow = 3'(r);
      #1 got[r] = bus.Cout;
    end
  endtask

  // Skewed pass: row i / column j lag by i / j enabled cycles.
  task automatic run_pass(int stall_at, int stall_len, int wr_at);
    int e, stalled;
    bit wr_now;
    e = 0; stalled = 0; done_first = -1; done_cnt = 0;
    for (int cyc = 1; cyc <= PASS + stall_len + 3; cyc++) begin
      wr_now = 0;
      bus.WrEn = 1'b0;
      if (e == stall_at && stalled < stall_len) begin
        bus.en = 1'b0; bus.A = '0; bus.B = '0;
        stalled++;
      end else if (e < PASS) begin
        bus.en = 1'b1;
        for (int i = 0; i < DIM; i++) begin
          bus.A[i] = '0; bus.B[i] = '0;
          if (e - i >= 0 && e - i < DIM) begin
            bus.A[i] = 8'(Am[i][e-i]);
            bus.B[i] = 8'(Bm[e-i][i]);
          end
        end
        if (e == wr_at) begin
          wr_now = 1; bus.WrEn = 1'b1; bus.Crow = 3'd3;
          for (int j = 0; j < DIM; j++) bus.Cin[j] = 16'h0100;
        end
        e++;
      end else begin
        idle();
      end
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_first < 0) done_first = cyc + 1;
      end
      if (wr_now) wr_row = bus.Cout;
    end
    idle();
  endtask

  task automatic test_reset();
    bus.en = 1'b1; bus.WrEn = 1'b0; bus.Crow = '0; bus.Cin = '0;
    for (int i = 0; i < DIM; i++) begin bus.A[i] = 8'd5; bus.B[i] = 8'd5; end
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.done !== 1'b0) begin
        errors++; $display("FAIL reset_done cyc%0d: got %b expected 0", c, bus.done);
      end
    end
    rst_n = 1'b1; idle();
    read_C();
    for (int r = 0; r < DIM; r++) begin
      checks++;
      if (got[r] !== '0) begin
        errors++; $display("FAIL reset_row%0d: got %h expected 0", r, got[r]);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.en = 1'b1; bus.A[0] = 8'sd3; bus.B[0] = 8'sd4;
    @(posedge clk); #1;
    idle();
    read_C();
    for (int r = 0; r < DIM; r++) begin
      er = '0;
      if (r == 0) er[0] = 16'd12;
      checks++;
      if (got[r] !== er) begin
        errors++; $display("FAIL single_row%0d: got %h expected %h", r, got[r], er);
      end
    end
  endtask

  task automatic test_identity();
    do_reset();
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        Am[i][j] = (i == j) ? 1 : 0; Bm[i][j] = rnd8();
      end
    run_pass(-1, 0, -1);
    checks++;
    if (done_first != PASS + 1 || done_cnt != 1) begin
      errors++; $display("FAIL ident_done: got cycle %0d count %0d expected cycle %0d count 1",
                         done_first, done_cnt, PASS + 1);
    end
    read_C();
    for (int r = 0; r < DIM; r++) begin
      for (int j = 0; j < DIM; j++) er[j] = 16'(Bm[r][j]);
      checks++;
      if (got[r] !== er) begin
        errors++; $display("FAIL ident_row%0d: got %h expected %h", r, got[r], er);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 2; n++) begin
      do_reset();
      rand_mats();
      model(-1);
      run_pass(-1, 0, -1);
      checks++;
      if (done_first != PASS + 1 || done_cnt != 1) begin
        errors++; $display("FAIL rand_done: got cycle %0d count %0d expected cycle %0d",
                           done_first, done_cnt, PASS + 1);
      end
      read_C();
      for (int r = 0; r < DIM; r++) begin
        for (int j = 0; j < DIM; j++) er[j] = 16'(Cx[r][j]);
        checks++;
        if (got[r] !== er) begin
          errors++; $display("FAIL rand_row%0d: got %h expected %h", r, got[r], er);
        end
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    rand_mats();
    model(-1);
    run_pass(10, 5, -1);
    checks++;
    if (done_first != PASS + 6 || done_cnt != 1) begin
      errors++; $display("FAIL stall_done: got cycle %0d count %0d expected cycle %0d count 1",
                         done_first, done_cnt, PASS + 6);
    end
    read_C();
    for (int r = 0; r < DIM; r++) begin
      for (int j = 0; j < DIM; j++) er[j] = 16'(Cx[r][j]);
      checks++;
      if (got[r] !== er) begin
        errors++; $display("FAIL stall_row%0d: got %h expected %h", r, got[r], er);
      end
    end
  endtask

  task automatic test_write();
    do_reset();
    rand_mats();
    Am[3][0] = 2; Am[3][1] = 2;
    model(5);
    run_pass(-1, 0, 5);
    for (int j = 0; j < DIM; j++) er[j] = 16'h0100;
    checks++;
    if (wr_row !== er) begin
      errors++; $display("FAIL write_now: got %h expected %h", wr_row, er);
    end
    checks++;
    if (done_first != PASS + 1 || done_cnt != 1) begin
      errors++; $display("FAIL write_done: got cycle %0d count %0d expected cycle %0d",
                         done_first, done_cnt, PASS + 1);
    end
    read_C();
    for (int r = 0; r < DIM; r++) begin
      for (int j = 0; j < DIM; j++) er[j] = 16'(Cx[r][j]);
      checks++;
      if (got[r] !== er) begin
        errors++; $display("FAIL write_row%0d: got %h expected %h", r, got[r], er);
      end
    end
  endtask

  task automatic test_sat();
    int expv;
    do_reset();
    bus.en = 1'b1; bus.A[0] = 8'sd127; bus.B[0] = 8'sd127;
    repeat (3) @(posedge clk);
    #1 idle();
    expv = 0;
    for (int n = 0; n < 3; n++) expv = accum(expv, 127 * 127);
    er = '0;
    er[0] = 16'(expv);
    bus.Crow = '0;
    #1;
    checks++;
    if (bus.Cout !== er) begin
      errors++; $display("FAIL sat_row0: got %h expected %h", bus.Cout, er);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.en = 1'b1;
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < DIM; i++) begin bus.A[i] = 8'(rnd8()); bus.B[i] = 8'(rnd8()); end
      @(posedge clk); #1;
    end
    do_reset();
    read_C();
    for (int r = 0; r < DIM; r++) begin
      checks++;
      if (got[r] !== '0) begin
        errors++; $display("FAIL midrst_clear_row%0d: got %h expected 0", r, got[r]);
      end
    end
    rand_mats();
    model(-1);
    run_pass(-1, 0, -1);
    checks++;
    if (done_first != PASS + 1 || done_cnt != 1) begin
      errors++; $display("FAIL midrst_done: got cycle %0d count %0d expected cycle %0d",
                         done_first, done_cnt, PASS + 1);
    end
    read_C();
    for (int r = 0; r < DIM; r++) begin
      for (int j = 0; j < DIM; j++) er[j] = 16'(Cx[r][j]);
      checks++;
      if (got[r] !== er) begin
        errors++; $display("FAIL midrst_row%0d: got %h expected %h", r, got[r], er);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_identity();
    test_random();
    test_stall();
    test_write();
    test_sat();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/systolic_array.md
SYSTOLIC_ARRAY -- requirements
Module: systolic_array

Interface
REQ-001 SHALL have parameter BITS_AB, default 8, signed width of A/B operands.
REQ-002 SHALL have parameter BITS_C, default 16, signed width of each accumulator.
REQ-003 SHALL have parameter DIM, default 8, array edge (DIM x DIM processing elements).
REQ-004 clk  input  1  sole clock; all state updates on posedge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 en  input  1  advance array: shift operands and accumulate.
REQ-007 WrEn  input  1  load Cin into accumulator row Crow.
REQ-008 A  input  [DIM-1:0] x BITS_AB signed  row-skewed operand, element i enters row i at column 0.
REQ-009 B  input  [DIM-1:0] x BITS_AB signed  column-skewed operand, element j enters column j at row 0.
REQ-010 Cin  input  [DIM-1:0] x BITS_C signed  row write data.
REQ-011 Crow  input  $clog2(DIM)  row select for write and read.
REQ-012 Cout  output  [DIM-1:0] x BITS_C signed  accumulator row Crow.
REQ-013 done  output  1  one-cycle pulse at end of a 3*DIM-2 cycle pass.

Function
REQ-014 Each PE(i,j) SHALL hold registers a_reg, b_reg, c; a_in = A[i] if j==0 else a_reg(i,j-1); b_in = B[j] if i==0 else b_reg(i-1,j).
REQ-015 On en=1: a_reg<=a_in, b_reg<=b_in, c<=c+a_in*b_in; on en=0 all PE state SHALL hold.
REQ-016 Product SHALL be full 2*BITS_AB signed, sign-extended to BITS_C before addition.
REQ-017 Operand presented at A[i] on cycle t SHALL reach column j on enabled cycle t+j; same for B down rows.
REQ-018 With skewed operand streams driven over 3*DIM-2 enabled cycles, c(i,j) SHALL equal sum_k A(i,k)*B(k,j).
REQ-019 Cout SHALL be a combinational read of c(Crow,*); a write is visible on Cout the cycle after the write edge.
REQ-020 WrEn=1 SHALL write Cin to row Crow; if en=1 same cycle, the write wins for row Crow, operand shifting and other rows proceed normally.
REQ-021 Pass counter SHALL increment on each en=1 cycle; on the edge where it reaches 3*DIM-2 it SHALL return to 0 and done SHALL be 1 for exactly the next cycle.
REQ-022 en deasserted mid-pass SHALL freeze the counter; done SHALL never assert while en has been low since the last increment.
REQ-023 WrEn SHALL NOT affect the pass counter or done.

Reset
REQ-024 rst_n=0 at posedge SHALL clear all a_reg, b_reg, c, pass counter and done to 0, overriding en and WrEn.
REQ-025 After reset Cout SHALL read 0 for every Crow and done SHALL be 0.
REQ-026 Reset mid-pass SHALL discard all partial sums; next pass starts at counter 0.

Configuration
REQ-027 Macro SYSTOLIC_SAT_EN defined: each accumulate (REQ-015) SHALL saturate to [-2^(BITS_C-1), 2^(BITS_C-1)-1].
REQ-028 SYSTOLIC_SAT_EN undefined: accumulate SHALL wrap modulo 2^BITS_C; WrEn writes unaffected in both builds.

Verification
REQ-029 rst_n=0 for 2 cycles with en=1, A[*]=5, B[*]=5 -> all Cout rows 0, done 0 throughout.
REQ-030 One en cycle with A[0]=3, B[0]=4, all else 0 -> Crow=0 gives Cout[0]=12, all other c=0; row 0 col 1 and row 1 col 0 remain 0.
REQ-031 A=identity, B=random, both skewed, 22 en cycles -> every row of C equals B row; done high only on cycle 23.
REQ-032 WrEn=1, Crow=3, Cin[*]=16'h0100 with en=1, A[3]=2 in flight -> row 3 reads 0100 next cycle; other rows accumulate normally.
REQ-033 PE(0,0) accumulates 127*127 three times (48387) -> SAT build Cout[0]=32767; wrap build Cout[0]=-17149.
REQ-034 en low 5 cycles starting at enabled cycle 10 of a pass -> final C identical to uninterrupted run; done delayed exactly 5 cycles.
